adder_share_sequencer: RTL and testbench
========================================

Name: adder_share_sequencer

Overview:
- Shares one W-bit ripple-carry adder slice among NREQ requesters.
- Each request is an N-bit add with carry-in. The slice processes it in N/W chunks over N/W cycles, least-significant chunk first, with a registered carry between chunks.
- Arbitration is round-robin. Requests and responses use valid/ready handshakes.
- Sits between datapath clients and the shared adder resource; the adder slice is internal to this block.

Parameters:
- N, 128, operand width in bits. Must be a multiple of W.
- W, 32, chunk width of the shared adder slice.
- NREQ, 2, number of requesters (≥2).
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant/accept. At most one bit is high.
- req_a  input  NREQ*N  operand A; requester r occupies bits [r*N +: N].
- req_b  input  NREQ*N  operand B, same packing as req_a.
- req_cin  input  NREQ  carry-in per requester.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_s  output  N  sum.
- rsp_cout  output  1  final carry-out.
- rsp_id  output  IDW  index of the requester that owns the result.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, any state, including mid-RUN or DONE):
  - state=IDLE, rr_ptr=0, chunk counter=0, carry register=0.
  - rsp_valid=0, rsp_s=0, rsp_cout=0, rsp_id=0, busy=0, req_ready=0.
  - An in-flight operation is discarded and no response is produced.
- Arbitration in IDLE:
  - req_ready is combinational.
  - Only the first requester with req_valid=1 is granted, searching from rr_ptr upward modulo NREQ.
  - No valid request → req_ready=0.
  - req_ready is always 0 outside IDLE.
- Handshake in cycle t (req_valid[g] & req_ready[g]):
  - Latch a, b, cin and g as the ID.
  - rr_ptr := (g+1) mod NREQ.
  - Go to RUN. The requester may change or drop its inputs from t+1 on.
- RUN, cycles t+1 … t+N/W, chunk k=0…N/W-1:
  - {c, s[kW +: W]} = a_chunk + b_chunk + carry_reg.
  - carry_reg := c.
  - carry_reg is loaded with the latched cin at the handshake.
  - After chunk N/W-1: rsp_cout := c, go to DONE.
- DONE, from cycle t+N/W+1:
  - rsp_valid=1; rsp_s, rsp_cout and rsp_id are stable.
  - Held indefinitely while rsp_ready=0.
  - rsp_valid & rsp_ready → IDLE.
  - A new grant cannot occur in the same cycle as the response handshake, so there is one IDLE bubble minimum.
- Throughput and latency:
  - Throughput is at most one request per N/W+2 cycles.
  - Latency from request handshake to rsp_valid is N/W+1 cycles.
- Arithmetic:
  - Result is exactly (A + B + cin) mod 2^N.
  - cout is bit N of the full sum.
  - Wrap-around is silent; there is no overflow flag.
- Partial sums:
  - rsp_s may hold partial sums during RUN.
  - Consumers must sample only when rsp_valid=1.
- Starvation: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,…
- req_valid deasserted before grant: no effect on state; the request is not remembered.

Test Plan:
- Reset, then req_valid[0]=1, a=128'hFFFF…FFFF, b=1, cin=0, handshake at cycle 0 → rsp_valid at cycle 5, rsp_s=0, rsp_cout=1, rsp_id=0.
- Requester 1 only: a=2^64-1, b=0, cin=1, rsp_ready tied high → rsp_s=2^64, rsp_cout=0, rsp_id=1. The carry crosses the chunk 1→2 boundary. busy falls one cycle after the response handshake.
- Both requesters valid continuously from reset, rsp_ready=1 → grant order 0,1,0,1. Consecutive grants are 6 cycles apart. Each rsp_id matches its requester's latched operands.
- Backpressure: rsp_ready=0 for 10 cycles in DONE → rsp_valid stays 1 with unchanged rsp_s, rsp_cout and rsp_id; req_ready stays 0. Raising rsp_ready returns the block to IDLE the next cycle.
- Assert rst in cycle 2 of RUN → all outputs 0 immediately, no response emitted. The next request computes correctly with rr_ptr=0, so requester 0 wins a tie.
- Random regression, 10k requests, NREQ=2 and 4, W=32 and W=8 → every response equals the reference {cout,s} = a+b+cin. No lost or duplicate responses.

Source files
------------

// File: rtl/adder_share_sequencer.sv
// Round-robin sequencer sharing one W-bit ripple-carry adder slice among NREQ
// requesters; each N-bit add runs LSB chunk first over N/W cycles.
module adder_share_sequencer #(
  parameter int unsigned N    = 128,
  parameter int unsigned W    = 32,
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_s,
  output logic              rsp_cout,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  localparam int unsigned NCH = N / W;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    a_sh, b_sh;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] rot;
  logic [IDW:0]    off;
  logic [IDW:0]    idx_sum;
  logic            found;
  logic [IDW-1:0]  gnt_id;
  logic            hs;
  logic [W:0]      chunk;
  logic [N-1:0]    a_sel, b_sel;

  // Round-robin search: first valid requester at or after rr_ptr, modulo NREQ
  always_comb begin
    rot     = NREQ'({req_valid, req_valid} >> rr_ptr);
    found   = 1'b0;
    off     = '0;
    for (logic [IDW:0] i = '0; i < (IDW+1)'(NREQ); i = i + 1'b1) begin
      if (!found && rot[i[IDW-1:0]]) begin
        found = 1'b1;
        off   = i;
      end
    end
    idx_sum = {1'b0, rr_ptr} + off;
    if (idx_sum >= (IDW+1)'(NREQ)) begin
      idx_sum = idx_sum - (IDW+1)'(NREQ);
    end
    gnt_id = idx_sum[IDW-1:0];
  end

  // Grant is only offered while idle and out of reset
  always_comb begin
    req_ready = '0;
    hs        = 1'b0;
    if (state == IDLE && !rst && found) begin
      req_ready = NREQ'(1) << gnt_id;
      hs        = 1'b1;
    end
  end

  assign a_sel = N'(req_a >> (gnt_id * N));
  assign b_sel = N'(req_b >> (gnt_id * N));
  assign chunk = {1'b0, a_sh[W-1:0]} + {1'b0, b_sh[W-1:0]} + (W+1)'(carry);

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = RUN;
      RUN:     if (cnt == LAST_CHUNK) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, chunked add with sum shifted in from the top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      rr_ptr   <= '0;
      rsp_s    <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            a_sh   <= a_sel;
            b_sh   <= b_sel;
            carry  <= req_cin[gnt_id];
            cnt    <= '0;
            rsp_id <= gnt_id;
            rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> W;
          b_sh  <= b_sh >> W;
          rsp_s <= (rsp_s >> W) | (N'(chunk[W-1:0]) << (N - W));
          carry <= chunk[W];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_CHUNK) rsp_cout <= chunk[W];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model (full-width add, fixed response latency, round-robin).
module tb_adder_share_sequencer;

  localparam int unsigned N    = 128;
  localparam int unsigned W    = 32;
  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int          NCH  = int'(N / W);

  typedef logic [N:0] val_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, req_cin;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready, rsp_cout, busy;
  logic [N-1:0]      rsp_s;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      a_in [NREQ];
  logic [N-1:0]      b_in [NREQ];

  for (genvar r = 0; r < NREQ; r++) begin : g_pack
    assign req_a[r*N +: N] = a_in[r];
    assign req_b[r*N +: N] = b_in[r];
  end

  adder_share_sequencer #(.N(N), .W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input val_t act, input val_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout (cycle %0d)", nm, cyc);
  endtask

  function automatic int first_valid(input int ptr, input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (ptr + i) % NREQ;
      if (v[IDW'(j)]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] rnd_op();
    logic [N-1:0] v;
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return '1;
    if (sel == 1) return '0;
    v = '0;
    for (int k = 0; k < int'((N + 31) / 32); k++) v = (v << 32) | N'($urandom);
    return v;
  endfunction

  // Transaction model: one job in flight, result visible NCH+1 cycles after grant
  bit           m_active = 1'b0;
  int           m_age = 0;
  int           m_ptr = 0;
  logic [N-1:0] m_s;
  logic         m_cout;
  int           m_id = 0;
  int           m_rsp_cnt = 0;
  int           dut_rsp_cnt = 0;
  int           gnt_id_q[$];
  int           gnt_cyc_q[$];

  // Per-cycle compare of DUT against the model, then model advance
  always @(negedge clk) begin : compare
    int g;
    int dg;
    bit exp_valid;
    logic [NREQ-1:0] exp_ready;
    logic [N:0] full;
    if (rst) begin
      chk("rst_req_ready", val_t'(req_ready), val_t'(0));
      chk("rst_rsp_valid", val_t'(rsp_valid), val_t'(0));
      chk("rst_rsp_s", val_t'(rsp_s), val_t'(0));
      chk("rst_rsp_cout", val_t'(rsp_cout), val_t'(0));
      chk("rst_rsp_id", val_t'(rsp_id), val_t'(0));
      chk("rst_busy", val_t'(busy), val_t'(0));
      m_active = 1'b0;
      m_ptr = 0;
    end else begin
      g = m_active ? -1 : first_valid(m_ptr, req_valid);
      exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
      exp_valid = m_active && (m_age >= NCH + 1);
      chk("req_ready", val_t'(req_ready), val_t'(exp_ready));
      chk("busy", val_t'(busy), val_t'(m_active));
      chk("rsp_valid", val_t'(rsp_valid), val_t'(exp_valid));
      if (exp_valid) begin
        chk("rsp_s", val_t'(rsp_s), val_t'(m_s));
        chk("rsp_cout", val_t'(rsp_cout), val_t'(m_cout));
        chk("rsp_id", val_t'(rsp_id), val_t'(m_id));
      end
      if (req_ready != '0) begin
        dg = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[IDW'(i)]) dg = i;
        gnt_id_q.push_back(dg);
        gnt_cyc_q.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) dut_rsp_cnt++;
      if (g >= 0) begin
        full = {1'b0, a_in[IDW'(g)]} + {1'b0, b_in[IDW'(g)]} + (N+1)'(req_cin[IDW'(g)]);
        m_s = full[N-1:0];
        m_cout = full[N];
        m_id = g;
        m_ptr = (g + 1) % NREQ;
        m_active = 1'b1;
        m_age = 1;
      end else if (m_active) begin
        if (exp_valid && rsp_ready) begin
          m_active = 1'b0;
          m_rsp_cnt++;
        end else begin
          m_age++;
        end
      end
    end
  end

  // Call right after the request handshake edge; lat counts cycles to rsp_valid
  task automatic wait_rsp(input string nm, output int lat);
    lat = 0;
    while (lat < 64) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) break;
    end
    if (rsp_valid !== 1'b1) timeout(nm);
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (c < 64) begin
      @(negedge clk);
      c++;
      if (busy === 1'b0) break;
    end
    if (busy !== 1'b0) timeout(nm);
  endtask

  task automatic wait_grants(input string nm, input int n);
    int c;
    c = 0;
    while (c < 200 && gnt_id_q.size() < n) begin
      @(negedge clk);
      c++;
    end
    if (gnt_id_q.size() < n) timeout(nm);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : stim
    int lat;
    logic [N-1:0] two64;
    rst = 1'b1;
    req_valid = '0;
    req_cin = '0;
    rsp_ready = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      a_in[r] = '0;
      b_in[r] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Requester 0: all-ones + 1 wraps to zero with carry-out
    @(posedge clk); #1;
    a_in[0] = '1; b_in[0] = N'(1); req_cin = '0; req_valid = NREQ'(1);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp("t1_rsp", lat);
    chk("t1_latency", val_t'(lat), val_t'(NCH + 1));
    chk("t1_s", val_t'(rsp_s), val_t'(0));
    chk("t1_cout", val_t'(rsp_cout), val_t'(1));
    chk("t1_id", val_t'(rsp_id), val_t'(0));

    // Backpressure: response held stable, no grants while DONE
    @(posedge clk); #1 req_valid = '1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", val_t'(rsp_valid), val_t'(1));
      chk("bp_s", val_t'(rsp_s), val_t'(0));
      chk("bp_cout", val_t'(rsp_cout), val_t'(1));
      chk("bp_id", val_t'(rsp_id), val_t'(0));
      chk("bp_req_ready", val_t'(req_ready), val_t'(0));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("bp_release_valid", val_t'(rsp_valid), val_t'(1));
    @(negedge clk);
    chk("bp_idle_valid", val_t'(rsp_valid), val_t'(0));
    chk("bp_idle_busy", val_t'(busy), val_t'(0));

    // Requester 1: carry ripples across the chunk 1->2 boundary
    two64 = N'(1) << 64;
    @(posedge clk); #1;
    a_in[1] = two64 - N'(1); b_in[1] = '0; req_cin = NREQ'(2); req_valid = NREQ'(2);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp("t2_rsp", lat);
    chk("t2_latency", val_t'(lat), val_t'(NCH + 1));
    chk("t2_s", val_t'(rsp_s), val_t'(two64));
    chk("t2_cout", val_t'(rsp_cout), val_t'(0));
    chk("t2_id", val_t'(rsp_id), val_t'(1));
    chk("t2_busy_at_hs", val_t'(busy), val_t'(1));
    @(negedge clk);
    chk("t2_busy_after", val_t'(busy), val_t'(0));

    // Fairness: all requesters continuously valid
    @(posedge clk); #1;
    gnt_id_q.delete(); gnt_cyc_q.delete();
    for (int r = 0; r < NREQ; r++) begin
      a_in[r] = rnd_op(); b_in[r] = rnd_op();
    end
    req_cin = NREQ'($urandom);
    req_valid = '1;
    wait_grants("t3_grants", 4);
    @(posedge clk); #1 req_valid = '0;
    if (gnt_id_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t3_order", val_t'(gnt_id_q[i]), val_t'(i % NREQ));
      for (int i = 0; i < 3; i++)
        chk("t3_spacing", val_t'(gnt_cyc_q[i+1] - gnt_cyc_q[i]), val_t'(NCH + 2));
    end
    wait_idle("t3_idle");

    // Reset mid-RUN: in-flight job dropped, pointer back to requester 0
    @(posedge clk); #1;
    a_in[0] = rnd_op(); b_in[0] = rnd_op(); req_valid = NREQ'(1);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1 rst = 1'b1; req_valid = '1;
    #1;
    chk("t4_rst_valid", val_t'(rsp_valid), val_t'(0));
    chk("t4_rst_busy", val_t'(busy), val_t'(0));
    chk("t4_rst_s", val_t'(rsp_s), val_t'(0));
    chk("t4_rst_id", val_t'(rsp_id), val_t'(0));
    chk("t4_rst_req_ready", val_t'(req_ready), val_t'(0));
    @(posedge clk); #1;
    gnt_id_q.delete(); gnt_cyc_q.delete();
    for (int r = 0; r < NREQ; r++) begin
      a_in[r] = rnd_op(); b_in[r] = rnd_op();
    end
    rst = 1'b0;
    wait_grants("t4_grant", 1);
    @(posedge clk); #1 req_valid = '0;
    if (gnt_id_q.size() >= 1) chk("t4_first_grant", val_t'(gnt_id_q[0]), val_t'(0));
    wait_idle("t4_idle");

    // Randomized traffic with backpressure and occasional reset
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 3) == 0) begin
          a_in[r] = rnd_op(); b_in[r] = rnd_op();
        end
      end
      req_valid = NREQ'($urandom);
      req_cin   = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 999) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    wait_idle("rand_drain");
    chk("rand_rsp_count", val_t'(dut_rsp_cnt), val_t'(m_rsp_cnt));
    chk("rand_activity", val_t'(m_rsp_cnt > 1000), val_t'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
